// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stage-index type and saturating counter helper.
package pipe_ctrl_pkg;
    localparam int unsigned CNT_MAX_W  = 64;
    localparam int unsigned DEF_STAGES = 5;
    typedef logic [$clog2(DEF_STAGES)-1:0] stage_idx_t;
    function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                     input logic inc, input int unsigned w);
        logic [CNT_MAX_W-1:0] max_v;
        max_v = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - w);
        return (inc && v != max_v) ? v + CNT_MAX_W'(1) : v;
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one pipeline slot, a valid bit plus payload with kill > load > hold.
module pipe_slot #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              kill_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (kill_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: parametrised stall/flush pipeline backbone with saturating perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       in_ready_o,
    input  logic [STAGES-1:0]          stall_req_i,
    input  logic                       flush_i,
    input  logic [$clog2(STAGES)-1:0]  flush_upto_i,
    output logic [STAGES-1:0]          stage_valid_o,
    output logic [STAGES*DATA_W-1:0]   stage_data_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    input  logic                       out_ready_i,
    input  logic                       cnt_clr_i,
    output logic [CNT_W-1:0]           cycle_cnt_o,
    output logic [CNT_W-1:0]           retire_cnt_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o
);
    logic [STAGES-1:0] v, blk, kill, nv;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [CNT_W-1:0]  cyc_q, cyc_d, ret_q, ret_d, stl_q, stl_d, fls_q, fls_d;
    // Blocked chain runs oldest to youngest through a scalar so it stays a plain combinational chain.
    always_comb begin
        logic b;
        int   f;
        b = ~out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            b      = v[k] & (stall_req_i[k] | b);
            blk[k] = b;
        end
        f = (int'(flush_upto_i) > int'(STAGES) - 1) ? int'(STAGES) - 1 : int'(flush_upto_i);
        for (int k = 0; k < int'(STAGES); k++) kill[k] = flush_i && (k <= f);
        nv[0] = in_valid_i & ~flush_i;
        for (int k = 1; k < int'(STAGES); k++) nv[k] = v[k-1] & ~blk[k-1] & ~kill[k-1];
    end
    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        logic [DATA_W-1:0] src;
        if (g == 0) begin : g_head
            assign src = in_data_i;
        end else begin : g_body
            assign src = data_q[g-1];
        end
        pipe_slot #(.DATA_W(DATA_W)) u_slot (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load_i (~blk[g]),
            .kill_i (kill[g]),
            .valid_i(nv[g]),
            .data_i (src),
            .valid_o(v[g]),
            .data_o (data_q[g])
        );
        assign stage_data_o[g*DATA_W +: DATA_W] = data_q[g];
    end
    always_comb begin
        cyc_d = cnt_clr_i ? '0 : CNT_W'(sat_inc(CNT_MAX_W'(cyc_q), 1'b1, CNT_W));
        ret_d = cnt_clr_i ? '0 : CNT_W'(sat_inc(CNT_MAX_W'(ret_q), out_valid_o & out_ready_i, CNT_W));
        stl_d = cnt_clr_i ? '0 : CNT_W'(sat_inc(CNT_MAX_W'(stl_q), |blk, CNT_W));
        fls_d = cnt_clr_i ? '0 : CNT_W'(sat_inc(CNT_MAX_W'(fls_q), flush_i, CNT_W));
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
            stl_q <= stl_d;
            fls_q <= fls_d;
        end
    end
    assign in_ready_o    = ~blk[0];
    assign stage_valid_o = v;
    assign out_valid_o   = v[STAGES-1];
    assign out_data_o    = data_q[STAGES-1];
    assign cycle_cnt_o   = cyc_q;
    assign retire_cnt_o  = ret_q;
    assign stall_cnt_o   = stl_q;
    assign flush_cnt_o   = fls_q;
endmodule
